mem_arbiter: RTL and testbench

Single-port memory arbiter sharing one synchronous SRAM between the core's instruction-fetch port, the core's data (load/store) port and a debug/loader port. It sits between `rv_core` and a unified memory, replacing the separate imem/dmem.
- Fixed-priority arbitration with an instruction-starvation guard.
- Returns read data with one-cycle latency.
- Raises a stall to the core whenever a core request is not granted.
- Implements a debug halt mode that drains core traffic and then serves only the debug port.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_prio.sv | 28 ++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the unified-memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2,
        OWN_DBG  = 2'd3
    } rd_owner_e;

    function automatic logic is_core_owner(input rd_owner_e owner);
        return (owner == OWN_INST) || (owner == OWN_DATA);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - 3-input fixed-priority encoder (hi > mid > lo),
// rotate_i lifts lo to the top: lo > hi > mid.
module mem_arb_prio (
    input  logic hi_i,
    input  logic mid_i,
    input  logic lo_i,
    input  logic rotate_i,
    output logic gnt_hi_o,
    output logic gnt_mid_o,
    output logic gnt_lo_o
);

    always_comb begin
        gnt_hi_o  = 1'b0;
        gnt_mid_o = 1'b0;
        gnt_lo_o  = 1'b0;
        if (rotate_i && lo_i) begin
            gnt_lo_o = 1'b1;
        end else if (hi_i) begin
            gnt_hi_o = 1'b1;
        end else if (mid_i) begin
            gnt_mid_o = 1'b1;
        end else if (lo_i) begin
            gnt_lo_o = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port SRAM arbiter for inst, data and debug ports
// with starvation guard, one-cycle read return and debug halt mode.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_gnt_o,
    output logic              inst_rvalid_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    input  logic              dbg_halt_i,
    output logic              dbg_halted_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              core_stall_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e state_q, state_d;
    rd_owner_e  rd_owner_q, rd_owner_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    logic core_rd_q;
    logic core_block;
    logic starve_hit;
    logic p_data, p_dbg, p_inst;

    assign core_rd_q  = is_core_owner(rd_owner_q);
    assign starve_hit = (starve_cnt_q == STARVE_LIM);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (dbg_halt_i) begin
                    state_d = core_rd_q ? ST_DRAIN : ST_HALTED;
                end
            end
            ST_DRAIN:  state_d = dbg_halt_i ? ST_HALTED : ST_RUN;
            ST_HALTED: state_d = dbg_halt_i ? ST_HALTED : ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Core ports are blocked outside RUN and already in the cycle halt rises.
    assign core_block = (state_q != ST_RUN) || (state_d != ST_RUN);

    mem_arb_prio u_prio (
        .hi_i      (data_req_i & ~core_block),
        .mid_i     (dbg_req_i),
        .lo_i      (inst_req_i & ~core_block),
        .rotate_i  (starve_hit),
        .gnt_hi_o  (p_data),
        .gnt_mid_o (p_dbg),
        .gnt_lo_o  (p_inst)
    );

    assign inst_gnt_o = p_inst & ~rst_i;
    assign data_gnt_o = p_data & ~rst_i;
    assign dbg_gnt_o  = p_dbg  & ~rst_i;

    always_comb begin
        ram_en_o    = inst_gnt_o | data_gnt_o | dbg_gnt_o;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (inst_gnt_o) begin
            ram_addr_o = inst_addr_i;
        end else if (data_gnt_o) begin
            ram_we_o    = data_we_i;
            ram_addr_o  = data_addr_i;
            ram_wdata_o = data_wdata_i;
        end else if (dbg_gnt_o) begin
            ram_we_o    = dbg_we_i;
            ram_addr_o  = dbg_addr_i;
            ram_wdata_o = dbg_wdata_i;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == ST_RUN) begin
            if (inst_gnt_o) begin
                starve_cnt_d = 4'd0;
            end else if (inst_req_i && !starve_hit) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (inst_gnt_o) begin
            rd_owner_d = OWN_INST;
        end else if (data_gnt_o && !data_we_i) begin
            rd_owner_d = OWN_DATA;
        end else if (dbg_gnt_o && !dbg_we_i) begin
            rd_owner_d = OWN_DBG;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            rd_owner_q   <= OWN_NONE;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            rd_owner_q   <= rd_owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Gating with rst_i drops a response that was due in the reset cycle.
    assign inst_rvalid_o = ~rst_i & (rd_owner_q == OWN_INST);
    assign data_rvalid_o = ~rst_i & (rd_owner_q == OWN_DATA);
    assign dbg_rvalid_o  = ~rst_i & (rd_owner_q == OWN_DBG);
    assign dbg_halted_o  = ~rst_i & (state_q == ST_HALTED);
    assign rdata_o       = ram_rdata_i;

    assign core_stall_o = ~rst_i & ((inst_req_i & ~inst_gnt_o) | (data_req_i & ~data_gnt_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a behavioural SRAM
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic        inst_gnt_o, inst_rvalid_o;
    logic        data_req_i, data_we_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o;
    logic        dbg_req_i, dbg_we_i;
    logic [31:0] dbg_addr_i, dbg_wdata_i;
    logic        dbg_gnt_o, dbg_rvalid_o;
    logic        dbg_halt_i, dbg_halted_o;
    logic [31:0] rdata_o;
    logic        core_stall_o;
    logic        ram_en_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic        preload;

    logic [31:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .inst_req_i    (inst_req_i),
        .inst_addr_i   (inst_addr_i),
        .inst_gnt_o    (inst_gnt_o),
        .inst_rvalid_o (inst_rvalid_o),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .dbg_req_i     (dbg_req_i),
        .dbg_we_i      (dbg_we_i),
        .dbg_addr_i    (dbg_addr_i),
        .dbg_wdata_i   (dbg_wdata_i),
        .dbg_gnt_o     (dbg_gnt_o),
        .dbg_rvalid_o  (dbg_rvalid_o),
        .dbg_halt_i    (dbg_halt_i),
        .dbg_halted_o  (dbg_halted_o),
        .rdata_o       (rdata_o),
        .core_stall_o  (core_stall_o),
        .ram_en_o      (ram_en_o),
        .ram_we_o      (ram_we_o),
        .ram_addr_o    (ram_addr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_rdata_i   (ram_rdata_i)
    );

    always @(posedge clk_i) begin
        if (preload) begin
            mem[64] <= 32'hDEADBEEF;
        end else if (ram_en_o) begin
            if (ram_we_o) mem[ram_addr_o[9:2]] <= ram_wdata_o;
            else          ram_rdata_i <= mem[ram_addr_o[9:2]];
        end
    end

    // exp bits: {inst_gnt, data_gnt, dbg_gnt, inst_rv, data_rv, dbg_rv, stall, halted, ram_en, ram_we}
    typedef struct {
        logic        rst;
        logic        ireq;
        logic        dreq;
        logic        breq;
        logic        bwe;
        logic        halt;
        logic [9:0]  exp;
        logic        chk_rd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [0:31];

    function automatic vec_t mk(input logic rst, input logic ireq, input logic dreq,
                                input logic breq, input logic bwe, input logic halt,
                                input logic [9:0] exp, input logic chk_rd, input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.breq = breq; v.bwe = bwe;
        v.halt = halt; v.exp = exp; v.chk_rd = chk_rd; v.rd = rd;
        return v;
    endfunction

    function automatic logic [9:0] outs();
        return {inst_gnt_o, data_gnt_o, dbg_gnt_o, inst_rvalid_o, data_rvalid_o,
                dbg_rvalid_o, core_stall_o, dbg_halted_o, ram_en_o, ram_we_o};
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //                  rst ir dr br bw hl  expected       chk rdata
        vecs[0]  = mk(1, 1, 1, 1, 0, 0, 10'b0000000000, 0, 32'h0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0, 10'b1000000010, 0, 32'h0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 10'b0001000000, 1, 32'hDEADBEEF);
        vecs[3]  = mk(0, 0, 0, 1, 1, 0, 10'b0010000011, 0, 32'h0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 0, 10'b0100000010, 0, 32'h0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 10'b0000100000, 1, 32'h55);
        vecs[6]  = mk(0, 1, 1, 0, 0, 0, 10'b0100001010, 0, 32'h0);
        vecs[7]  = mk(0, 1, 1, 0, 0, 0, 10'b0100101010, 0, 32'h0);
        vecs[8]  = mk(0, 1, 1, 0, 0, 0, 10'b0100101010, 0, 32'h0);
        vecs[9]  = mk(0, 1, 1, 0, 0, 0, 10'b0100101010, 0, 32'h0);
        vecs[10] = mk(0, 1, 1, 0, 0, 0, 10'b1000101010, 0, 32'h0);
        vecs[11] = mk(0, 1, 1, 0, 0, 0, 10'b0101001010, 1, 32'hDEADBEEF);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 10'b0000100000, 0, 32'h0);
        vecs[13] = mk(0, 1, 1, 1, 0, 0, 10'b0100001010, 0, 32'h0);
        vecs[14] = mk(0, 1, 0, 1, 0, 0, 10'b0010101010, 0, 32'h0);
        vecs[15] = mk(0, 1, 0, 0, 0, 0, 10'b1000010010, 1, 32'h55);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 10'b0001000000, 1, 32'hDEADBEEF);
        vecs[17] = mk(0, 0, 1, 0, 0, 0, 10'b0100000010, 0, 32'h0);
        vecs[18] = mk(0, 0, 1, 0, 0, 1, 10'b0000101000, 1, 32'h55);
        vecs[19] = mk(0, 0, 1, 1, 0, 1, 10'b0010001010, 0, 32'h0);
        vecs[20] = mk(0, 0, 1, 1, 1, 1, 10'b0010011111, 1, 32'h55);
        vecs[21] = mk(0, 1, 1, 0, 0, 1, 10'b0000001100, 0, 32'h0);
        vecs[22] = mk(0, 1, 1, 0, 0, 0, 10'b0000001100, 0, 32'h0);
        vecs[23] = mk(0, 1, 1, 0, 0, 0, 10'b0100001010, 0, 32'h0);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 10'b0000100000, 0, 32'h0);
        vecs[25] = mk(0, 0, 1, 0, 0, 1, 10'b0000001000, 0, 32'h0);
        vecs[26] = mk(0, 0, 1, 0, 0, 1, 10'b0000001100, 0, 32'h0);
        vecs[27] = mk(0, 0, 1, 0, 0, 0, 10'b0000001100, 0, 32'h0);
        vecs[28] = mk(0, 0, 1, 0, 0, 0, 10'b0100000010, 0, 32'h0);
        vecs[29] = mk(1, 0, 0, 0, 0, 0, 10'b0000000000, 0, 32'h0);
        vecs[30] = mk(0, 0, 1, 0, 0, 0, 10'b0100000010, 0, 32'h0);
        vecs[31] = mk(0, 0, 0, 0, 0, 0, 10'b0000100000, 1, 32'h55);

        preload      = 1'b1;
        inst_addr_i  = 32'h100;
        data_addr_i  = 32'h20;
        dbg_addr_i   = 32'h20;
        data_wdata_i = 32'hA5;
        dbg_wdata_i  = 32'h55;
        data_we_i    = 1'b0;
        #1;

        for (int i = 0; i < 32; i++) begin
            rst_i      = vecs[i].rst;
            inst_req_i = vecs[i].ireq;
            data_req_i = vecs[i].dreq;
            dbg_req_i  = vecs[i].breq;
            dbg_we_i   = vecs[i].bwe;
            dbg_halt_i = vecs[i].halt;
            #2;
            checks++;
            if (outs() !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d outputs got=%b exp=%b", i, outs(), vecs[i].exp);
            end
            if (vecs[i].chk_rd) check32($sformatf("vec%0d rdata", i), rdata_o, vecs[i].rd);
            next_cycle();
            preload = 1'b0;
        end

        // Data write mirrored onto the RAM bus while inst waits, then read-back.
        inst_req_i = 1'b1; data_req_i = 1'b1; data_we_i = 1'b1;
        data_addr_i = 32'h40; data_wdata_i = 32'h1234;
        dbg_req_i = 1'b0; dbg_halt_i = 1'b0;
        #2;
        check32("wr gnt", {31'd0, data_gnt_o}, 32'd1);
        check32("wr ram_addr", ram_addr_o, 32'h40);
        check32("wr ram_wdata", ram_wdata_o, 32'h1234);
        check32("wr ram_we", {31'd0, ram_we_o}, 32'd1);
        check32("wr stall", {31'd0, core_stall_o}, 32'd1);
        next_cycle();
        data_req_i = 1'b0; data_we_i = 1'b0;
        #2;
        check32("inst ram_addr", ram_addr_o, 32'h100);
        check32("inst ram_we", {31'd0, ram_we_o}, 32'd0);
        check32("wr no rvalid", {31'd0, data_rvalid_o}, 32'd0);
        next_cycle();
        inst_req_i = 1'b0; data_req_i = 1'b1;
        #2;
        check32("rd gnt", {31'd0, data_gnt_o}, 32'd1);
        next_cycle();
        data_req_i = 1'b0;
        #2;
        check32("rd rvalid", {31'd0, data_rvalid_o}, 32'd1);
        check32("rd rdata", rdata_o, 32'h1234);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
